// File: rtl/tage_bank_if.sv
// Lookup/update/aging bundle between the predictor top (master) and one TAGE bank (slave).
// Slot s occupies bits [s*W +: W] of every packed per-slot field.
interface tage_bank_if #(
    parameter int SLOTS  = 2,
    parameter int HEIGHT = 2048,
    parameter int TAG_W  = 8,
    parameter int CTR_W  = 3,
    parameter int U_W    = 2
);
    localparam int IDX_W = $clog2(HEIGHT);

    logic                   en;
    logic [IDX_W-1:0]       lookup_idx;
    logic [TAG_W-1:0]       lookup_tag;
    logic [SLOTS-1:0]       update_en;
    logic [SLOTS-1:0]       provider;
    logic [SLOTS-1:0]       alloc;
    logic [SLOTS-1:0]       update_u_en;
    logic [SLOTS*U_W-1:0]   update_u;
    logic [SLOTS*CTR_W-1:0] update_ctr;
    logic [TAG_W-1:0]       update_tag;
    logic [IDX_W-1:0]       update_idx;
    logic                   alloc_fail;

    logic [SLOTS-1:0]       lookup_match;
    logic [SLOTS-1:0]       taken;
    logic [SLOTS*CTR_W-1:0] lookup_ctr;
    logic [SLOTS*U_W-1:0]   lookup_u;
    logic [SLOTS-1:0]       u_nz;
    logic                   ready;
    logic                   aging;

    modport master (
        output en, lookup_idx, lookup_tag, update_en, provider, alloc, update_u_en,
               update_u, update_ctr, update_tag, update_idx, alloc_fail,
        input  lookup_match, taken, lookup_ctr, lookup_u, u_nz, ready, aging
    );

    modport slave (
        input  en, lookup_idx, lookup_tag, update_en, provider, alloc, update_u_en,
               update_u, update_ctr, update_tag, update_idx, alloc_fail,
        output lookup_match, taken, lookup_ctr, lookup_u, u_nz, ready, aging
    );
endinterface

// File: rtl/tage_bank_table.sv
// One tagged TAGE bank: per-slot valid/tag/ctr/u storage, 1-cycle lookup with
// same-cycle write forwarding, a clear sweep after reset and periodic u aging.
module tage_bank_table #(
    parameter int SLOTS      = 2,
    parameter int HEIGHT     = 2048,
    parameter int TAG_W      = 8,
    parameter int CTR_W      = 3,
    parameter int U_W        = 2,
    parameter int AGE_THRESH = 256
) (
    input  logic       clk,
    input  logic       rst,
    tage_bank_if.slave bus
);
    localparam int IDX_W = $clog2(HEIGHT);
    localparam int CNT_W = $clog2(AGE_THRESH + 1);

    typedef enum logic [1:0] {INIT, IDLE, AGE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] age_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             age_hit;
    logic             sweep_init, sweep_age, rdy;

    logic             vld_mem [HEIGHT][SLOTS];
    logic [TAG_W-1:0] tag_mem [HEIGHT][SLOTS];
    logic [CTR_W-1:0] ctr_mem [HEIGHT][SLOTS];
    logic [U_W-1:0]   u_mem   [HEIGHT][SLOTS];

    logic [SLOTS-1:0] wr_tc, wr_u, wr_age;
    logic             rd_vld [SLOTS];
    logic [TAG_W-1:0] rd_tag [SLOTS];
    logic [CTR_W-1:0] rd_ctr [SLOTS];
    logic [U_W-1:0]   rd_u   [SLOTS];

    logic [SLOTS-1:0]       match_p1;
    logic [SLOTS*CTR_W-1:0] ctr_p1;
    logic [SLOTS*U_W-1:0]   u_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(AGE_THRESH)) ? v : v + CNT_W'(1);
    endfunction

    assign cnt_inc = sat_inc(age_cnt);
    assign age_hit = (state == IDLE) && bus.alloc_fail && (cnt_inc == CNT_W'(AGE_THRESH));

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (ptr == IDX_W'(HEIGHT - 1)) state_nxt = IDLE;
            IDLE:    if (age_hit) state_nxt = AGE;
            AGE:     if (ptr == IDX_W'(HEIGHT - 1)) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        sweep_init = (state == INIT);
        sweep_age  = (state == AGE);
        rdy        = (state != INIT);
        bus.ready  = rdy;
        bus.aging  = sweep_age;
    end

    // Sweep pointer wraps to 0 after HEIGHT-1, so each sweep starts at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            age_cnt <= '0;
        end else begin
            if (sweep_init || sweep_age) ptr <= ptr + IDX_W'(1);
            if (age_hit)                                   age_cnt <= '0;
            else if ((state == IDLE) && bus.alloc_fail)    age_cnt <= cnt_inc;
        end
    end

    // Aging of a slot yields to an update u-write landing on the sweep index.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            wr_tc[s]  = rdy && bus.update_en[s] && (bus.provider[s] || bus.alloc[s]);
            wr_u[s]   = rdy && bus.update_en[s] && (bus.update_u_en[s] || bus.alloc[s]);
            wr_age[s] = sweep_age && !(wr_u[s] && (bus.update_idx == ptr));
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < SLOTS; s++) begin
            if (sweep_init) begin
                vld_mem[ptr][s] <= 1'b0;
                ctr_mem[ptr][s] <= '0;
                u_mem[ptr][s]   <= '0;
            end
            if (wr_tc[s]) begin
                vld_mem[bus.update_idx][s] <= 1'b1;
                tag_mem[bus.update_idx][s] <= bus.update_tag;
                ctr_mem[bus.update_idx][s] <= bus.update_ctr[s*CTR_W +: CTR_W];
            end
            if (wr_age[s]) u_mem[ptr][s] <= u_mem[ptr][s] >> 1;
            if (wr_u[s])   u_mem[bus.update_idx][s] <= bus.update_u[s*U_W +: U_W];
        end
    end

    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            rd_vld[s] = vld_mem[bus.lookup_idx][s];
            rd_tag[s] = tag_mem[bus.lookup_idx][s];
            rd_ctr[s] = ctr_mem[bus.lookup_idx][s];
            rd_u[s]   = u_mem[bus.lookup_idx][s];
            if (wr_tc[s] && (bus.update_idx == bus.lookup_idx)) begin
                rd_vld[s] = 1'b1;
                rd_tag[s] = bus.update_tag;
                rd_ctr[s] = bus.update_ctr[s*CTR_W +: CTR_W];
            end
            if (wr_age[s] && (ptr == bus.lookup_idx)) rd_u[s] = rd_u[s] >> 1;
            if (wr_u[s] && (bus.update_idx == bus.lookup_idx))
                rd_u[s] = bus.update_u[s*U_W +: U_W];
        end
    end

    // ---- stage p1: registered lookup result ----
    always_ff @(posedge clk) begin
        if (rst || sweep_init) begin
            match_p1 <= '0;
            ctr_p1   <= '0;
            u_p1     <= '0;
        end else if (bus.en) begin
            for (int s = 0; s < SLOTS; s++) begin
                match_p1[s]              <= rd_vld[s] && (rd_tag[s] == bus.lookup_tag);
                ctr_p1[s*CTR_W +: CTR_W] <= rd_ctr[s];
                u_p1[s*U_W +: U_W]       <= rd_u[s];
            end
        end
    end

    always_comb begin
        bus.lookup_match = match_p1;
        bus.lookup_ctr   = ctr_p1;
        bus.lookup_u     = u_p1;
        bus.taken        = '0;
        bus.u_nz         = '0;
        for (int s = 0; s < SLOTS; s++) begin
            bus.taken[s] = ctr_p1[s*CTR_W + CTR_W - 1];
            bus.u_nz[s]  = |u_p1[s*U_W +: U_W];
        end
    end
endmodule

// File: tb/tb_tage_bank_table.sv
// Directed bench for tage_bank_table at HEIGHT=16, SLOTS=2, AGE_THRESH=4.
module tb_tage_bank_table;
    localparam int SLOTS = 2, HEIGHT = 16, TAG_W = 8, CTR_W = 3, U_W = 2, AGE_THRESH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;
    int   n;

    always #5 clk = ~clk;

    tage_bank_if #(.SLOTS(SLOTS), .HEIGHT(HEIGHT), .TAG_W(TAG_W), .CTR_W(CTR_W), .U_W(U_W)) bus ();

    tage_bank_table #(
        .SLOTS(SLOTS), .HEIGHT(HEIGHT), .TAG_W(TAG_W), .CTR_W(CTR_W), .U_W(U_W),
        .AGE_THRESH(AGE_THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_upd();
        bus.update_en   = '0;
        bus.provider    = '0;
        bus.alloc       = '0;
        bus.update_u_en = '0;
        bus.update_u    = '0;
        bus.update_ctr  = '0;
        bus.update_tag  = '0;
        bus.update_idx  = '0;
    endtask

    task automatic lookup(input int idx, input int tag);
        bus.en         = 1'b1;
        bus.lookup_idx = 4'(idx);
        bus.lookup_tag = 8'(tag);
        step();
        bus.en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en = 1'b0; bus.lookup_idx = '0; bus.lookup_tag = '0; bus.alloc_fail = 1'b0;
        clr_upd();

        // reset and init sweep
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_match", 32'(bus.lookup_match), 0);
        chk("rst_aging", 32'(bus.aging), 0);
        n = 0;
        while (!bus.ready && n < 40) begin step(); n++; end
        chk("init_len", 32'(n), 16);

        lookup(3, 0);
        chk("miss3_match", 32'(bus.lookup_match), 0);

        // alloc slot0 idx5 tag 3C ctr 4 u 0
        bus.update_en = 2'b01; bus.alloc = 2'b01; bus.update_idx = 4'd5;
        bus.update_tag = 8'h3C; bus.update_ctr = 6'b000_100; bus.update_u = '0;
        step();
        clr_upd();
        lookup(5, 'h3C);
        chk("alloc_match", 32'(bus.lookup_match), 'b01);
        chk("alloc_taken", 32'(bus.taken), 'b01);
        chk("alloc_ctr0", 32'(bus.lookup_ctr[2:0]), 4);
        chk("alloc_unz", 32'(bus.u_nz), 0);

        // same-cycle provider update with lookup at idx5
        bus.update_en = 2'b01; bus.provider = 2'b01; bus.update_idx = 4'd5;
        bus.update_tag = 8'h3C; bus.update_ctr = 6'b000_010;
        lookup(5, 'h3C);
        clr_upd();
        chk("fwd_ctr0", 32'(bus.lookup_ctr[2:0]), 2);
        chk("fwd_taken", 32'(bus.taken), 0);
        chk("fwd_match", 32'(bus.lookup_match), 'b01);

        // u-only write idx7 slot1 = 3, forwarded; valid stays clear
        bus.update_en = 2'b10; bus.update_u_en = 2'b10; bus.update_idx = 4'd7;
        bus.update_u = 4'b1100;
        lookup(7, 0);
        clr_upd();
        chk("ufwd_u", 32'(bus.lookup_u), 'b1100);
        chk("ufwd_unz", 32'(bus.u_nz), 'b10);
        chk("ufwd_match", 32'(bus.lookup_match), 0);

        // four alloc_fail pulses trigger aging
        for (int i = 0; i < 3; i++) begin
            bus.alloc_fail = 1'b1; step();
            bus.alloc_fail = 1'b0; step();
            chk("pre_age", 32'(bus.aging), 0);
        end
        bus.alloc_fail = 1'b1; step();
        chk("age_start", 32'(bus.aging), 1);

        // sweep: alloc_fail held (ignored), update wins at ptr2, aging forwarded at ptr7
        n = 0;
        while (bus.aging && n < 40) begin
            if (n == 2) begin
                bus.update_en = 2'b01; bus.update_u_en = 2'b01; bus.update_idx = 4'd2;
                bus.update_u = 4'b0011; bus.en = 1'b1; bus.lookup_idx = 4'd2;
            end else if (n == 7) begin
                bus.en = 1'b1; bus.lookup_idx = 4'd7;
            end
            step();
            n++;
            bus.en = 1'b0;
            clr_upd();
            if (n == 3) chk("age_upd_wins", 32'(bus.lookup_u[1:0]), 3);
            if (n == 8) chk("age_fwd_u1", 32'(bus.lookup_u[3:2]), 1);
        end
        bus.alloc_fail = 1'b0;
        chk("age_len", 32'(n), 16);

        lookup(7, 0);
        chk("aged_u7", 32'(bus.lookup_u), 'b0100);
        chk("aged_unz7", 32'(bus.u_nz), 'b10);
        lookup(2, 0);
        chk("kept_u2", 32'(bus.lookup_u[1:0]), 3);
        lookup(5, 'h3C);
        chk("kept5", 32'({bus.lookup_match, bus.lookup_ctr}), 'b01_000010);

        // a single post-sweep pulse must not restart aging
        bus.alloc_fail = 1'b1; step();
        bus.alloc_fail = 1'b0; step();
        chk("af_ignored", 32'(bus.aging), 0);

        // stall holds outputs
        lookup(5, 'h3C);
        for (int i = 0; i < 3; i++) begin
            bus.lookup_idx = 4'(i * 3 + 2);
            bus.lookup_tag = 8'h00;
            step();
            chk("hold", 32'({bus.lookup_match, bus.lookup_ctr, bus.lookup_u, bus.taken, bus.u_nz}),
                'b01_000010_0000_00_00);
        end

        // three more pulses complete the count of 4
        for (int i = 0; i < 3; i++) begin bus.alloc_fail = 1'b1; step(); end
        bus.alloc_fail = 1'b0;
        chk("age_trig2", 32'(bus.aging), 1);
        for (int i = 0; i < 6; i++) step();

        rst = 1'b1; step(); rst = 1'b0;
        chk("midage_ready", 32'(bus.ready), 0);
        chk("midage_aging", 32'(bus.aging), 0);
        chk("midage_match", 32'(bus.lookup_match), 0);
        n = 0;
        while (!bus.ready && n < 40) begin
            if (n == 12) begin
                bus.update_en = 2'b01; bus.alloc = 2'b01; bus.update_idx = 4'd9;
                bus.update_tag = 8'h11; bus.update_ctr = 6'b000_111;
            end
            step();
            n++;
            clr_upd();
        end
        chk("reinit_len", 32'(n), 16);
        lookup(5, 'h3C);
        chk("reinit_m5", 32'(bus.lookup_match), 0);
        lookup(7, 0);
        chk("reinit_u7", 32'({bus.lookup_match, bus.lookup_u}), 0);
        lookup(9, 'h11);
        chk("init_drop9", 32'(bus.lookup_match), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
